// File: rtl/testframe_pkg.sv
// Shared constants, state encoding and helpers for the GMII test frame source.
// Lengths are 11 bits wide to match the frame byte index counter.
package testframe_pkg;

   localparam logic [7:0]  PREAMBLE_BYTE      = 8'h55;
   localparam logic [7:0]  SFD_BYTE           = 8'hD5;
   localparam logic [10:0] PREAMBLE_LEN       = 11'd7;
   localparam logic [10:0] HDR_LEN            = 11'd42;
   localparam logic [10:0] TRAILER_LEN        = 11'd18;
   localparam logic [10:0] FCS_LEN            = 11'd4;
   localparam logic [10:0] IFG_LEN            = 11'd12;
   localparam logic [10:0] MIN_LEN            = 11'd64;
   localparam logic [10:0] MAX_LEN            = 11'd1518;
   localparam logic [15:0] TESTFRAME_UDP_PORT = 16'h0007;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SFD,
      ST_HEADER,
      ST_PAD,
      ST_TRAILER,
      ST_FCS,
      ST_IFG
   } state_e;

   function automatic logic [10:0] clamp_len(input logic [10:0] l);
      if (l < MIN_LEN)      return MIN_LEN;
      else if (l > MAX_LEN) return MAX_LEN;
      else                  return l;
   endfunction

   // Ones-complement sum of the ten IPv4 header words (checksum word = 0).
   // Ten 16-bit words fit in 20 bits, so two folds always clear the carry.
   function automatic logic [15:0] ip_csum(input logic [10:0] len,
                                           input logic [31:0] sip,
                                           input logic [31:0] dip);
      logic [19:0] s;
      s = 20'h04500 + {9'd0, len - 11'd18} + 20'h04000 + 20'h04011
        + {4'd0, sip[31:16]} + {4'd0, sip[15:0]}
        + {4'd0, dip[31:16]} + {4'd0, dip[15:0]};
      s = {4'd0, s[15:0]} + {16'd0, s[19:16]};
      s = {4'd0, s[15:0]} + {16'd0, s[19:16]};
      return ~s[15:0];
   endfunction

endpackage

// File: rtl/testframe_generator_crc32_d8.sv
// Combinational Ethernet CRC-32 (reflected 0x04C11DB7) update for one byte.
// Ports: crc_in[31:0] running CRC, d[7:0] data byte (LSB first), crc_out[31:0].
module crc32_d8 (
   input  logic [31:0] crc_in,
   input  logic [7:0]  d,
   output logic [31:0] crc_out
);

   localparam logic [31:0] POLY_REFL = 32'hEDB88320;

   logic [31:0] c;

   always_comb begin
      c = crc_in ^ {24'd0, d};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
      end
      crc_out = c;
   end

endmodule

// File: rtl/testframe_generator.sv
// GMII TX test frame source: preamble, SFD, Eth/IPv4/UDP header, pad, seq/ts trailer, FCS, IFG.
// Ports: clk, reset (async, high), start, frame_len[10:0], ts_sec[47:0], ts_nsec[31:0] in;
//        busy, frame_done, tx_seq_num[63:0], gmii_d[7:0], gmii_en, gmii_er out.
module testframe_generator
   import testframe_pkg::*;
#(
   parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
   parameter logic [47:0] SRC_MAC   = 48'h0200_0000_0001,
   parameter logic [31:0] SRC_IP    = 32'hC0A8_0001,
   parameter logic [31:0] DST_IP    = 32'hC0A8_0002,
   parameter logic [15:0] UDP_SPORT = 16'h0400
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [10:0] frame_len,
   input  logic [47:0] ts_sec,
   input  logic [31:0] ts_nsec,
   output logic        busy,
   output logic        frame_done,
   output logic [63:0] tx_seq_num,
   output logic [7:0]  gmii_d,
   output logic        gmii_en,
   output logic        gmii_er
);

   state_e state_q, state_d;
   logic [10:0]  cnt_q, cnt_d;
   logic [10:0]  len_q, len_d;
   logic [63:0]  seq_q, seq_d;
   logic [63:0]  tseq_q, tseq_d;
   logic [79:0]  ts_q, ts_d;
   logic [15:0]  csum_q, csum_d;
   logic [31:0]  crc_q, crc_d, crc_nxt;
   logic [7:0]   d_q, d_d;
   logic         en_q, en_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic         accept;
   logic [335:0] hdr_vec;
   logic [143:0] trl_vec;
   logic [10:0]  trl_k, fcs_k;
   logic [7:0]   hdr_byte, trl_byte, fcs_byte;

   crc32_d8 u_crc (
      .crc_in  (crc_q),
      .d       (d_q),
      .crc_out (crc_nxt)
   );

   assign hdr_vec = {DST_MAC, SRC_MAC, 16'h0800, 8'h45, 8'h00,
                     {5'd0, len_q - 11'd18}, 16'h0000, 16'h4000,
                     8'h40, 8'h11, csum_q, SRC_IP, DST_IP, UDP_SPORT,
                     TESTFRAME_UDP_PORT, {5'd0, len_q - 11'd38}, 16'h0000};
   assign trl_vec = {tseq_q, ts_q};

   // Next state; cnt is the frame byte index from HEADER through FCS.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 11'd1;
      len_d   = len_q;
      seq_d   = seq_q;
      tseq_d  = tseq_q;
      accept  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            cnt_d  = '0;
            accept = start;
         end
         ST_PREAMBLE: begin
            if (cnt_q == PREAMBLE_LEN - 11'd1) begin
               state_d = ST_SFD;
               cnt_d   = '0;
            end
         end
         ST_SFD: begin
            state_d = ST_HEADER;
            cnt_d   = '0;
         end
         ST_HEADER: begin
            if (cnt_q == HDR_LEN - 11'd1)
               state_d = (len_q == MIN_LEN) ? ST_TRAILER : ST_PAD;
         end
         ST_PAD: begin
            if (cnt_q == len_q - TRAILER_LEN - FCS_LEN - 11'd1)
               state_d = ST_TRAILER;
         end
         ST_TRAILER: begin
            if (cnt_q == len_q - FCS_LEN - 11'd1)
               state_d = ST_FCS;
         end
         ST_FCS: begin
            if (cnt_q == len_q - 11'd1) begin
               state_d = ST_IFG;
               cnt_d   = '0;
               seq_d   = seq_q + 64'd1;
            end
         end
         ST_IFG: begin
            if (cnt_q == IFG_LEN - 11'd1) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               accept  = start;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      if (accept) begin
         state_d = ST_PREAMBLE;
         cnt_d   = '0;
         len_d   = clamp_len(frame_len);
         tseq_d  = seq_q;
      end
   end

   // CRC covers bytes already on the wire; crc_d already includes the byte
   // now being sent, so the FCS bytes can be taken from it directly.
   always_comb begin
      crc_d = crc_q;
      if (state_q == ST_SFD)
         crc_d = '1;
      else if (state_q == ST_HEADER || state_q == ST_PAD ||
               state_q == ST_TRAILER)
         crc_d = crc_nxt;
      csum_d = csum_q;
      if (state_q == ST_PREAMBLE)
         csum_d = ip_csum(len_q, SRC_IP, DST_IP);
      ts_d = ts_q;
      if (state_d == ST_TRAILER && state_q != ST_TRAILER)
         ts_d = {ts_sec, ts_nsec};
      done_d = (state_q == ST_FCS) && (state_d == ST_IFG);
      busy_d = (state_d != ST_IDLE);
   end

   // Byte for the slot being entered; ts bytes come late enough in the
   // trailer that ts_q is already loaded when they are selected.
   always_comb begin
      trl_k    = cnt_d - (len_q - TRAILER_LEN - FCS_LEN);
      fcs_k    = cnt_d - (len_q - FCS_LEN);
      hdr_byte = '0;
      trl_byte = '0;
      fcs_byte = '0;
      for (int i = 0; i < 42; i++)
         if (cnt_d == 11'(i)) hdr_byte = hdr_vec[8*(41-i) +: 8];
      for (int i = 0; i < 18; i++)
         if (trl_k == 11'(i)) trl_byte = trl_vec[8*(17-i) +: 8];
      for (int i = 0; i < 4; i++)
         if (fcs_k == 11'(i)) fcs_byte = ~crc_d[8*i +: 8];
   end

   always_comb begin
      en_d = 1'b1;
      d_d  = '0;
      unique case (state_d)
         ST_PREAMBLE: d_d = PREAMBLE_BYTE;
         ST_SFD:      d_d = SFD_BYTE;
         ST_HEADER:   d_d = hdr_byte;
         ST_PAD:      d_d = 8'h00;
         ST_TRAILER:  d_d = trl_byte;
         ST_FCS:      d_d = fcs_byte;
         default:     en_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         len_q   <= MIN_LEN;
         seq_q   <= '0;
         tseq_q  <= '0;
         ts_q    <= '0;
         csum_q  <= '0;
         crc_q   <= '1;
         d_q     <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         seq_q   <= seq_d;
         tseq_q  <= tseq_d;
         ts_q    <= ts_d;
         csum_q  <= csum_d;
         crc_q   <= crc_d;
         d_q     <= d_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign gmii_d     = d_q;
   assign gmii_en    = en_q;
   assign gmii_er    = 1'b0;
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign tx_seq_num = seq_q;

endmodule

// File: tb/tb_testframe_generator.sv
// Self-checking bench for testframe_generator: captures GMII frames and compares
// them with a byte-level frame model and a receiver-side parser.
module tb_testframe_generator;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [10:0] frame_len;
   logic [47:0] ts_sec;
   logic [31:0] ts_nsec;
   logic        busy, frame_done;
   logic [63:0] tx_seq_num;
   logic [7:0]  gmii_d;
   logic        gmii_en, gmii_er;

   int checks = 0;
   int failures = 0;

   logic [7:0]  rx[$];
   logic [79:0] rx_ts[$];
   logic [7:0]  exp_q[$];
   logic [63:0] exp_seq;

   testframe_generator dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .frame_len  (frame_len),
      .ts_sec     (ts_sec),
      .ts_nsec    (ts_nsec),
      .busy       (busy),
      .frame_done (frame_done),
      .tx_seq_num (tx_seq_num),
      .gmii_d     (gmii_d),
      .gmii_en    (gmii_en),
      .gmii_er    (gmii_er)
   );

   initial forever #4 clk = ~clk;

   initial begin
      ts_sec  = 48'h0000_6543_2100;
      ts_nsec = 32'h3B9A_C900;
      forever begin
         @(posedge clk);
         #2;
         ts_sec  = ts_sec + 48'd1;
         ts_nsec = ts_nsec + 32'd3;
      end
   end

   function automatic int clamp_l(input int l);
      return (l < 64) ? 64 : ((l > 1518) ? 1518 : l);
   endfunction

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   task automatic build_expected(input int L, input logic [63:0] seq, input logic [79:0] ts);
      logic [7:0]  h[42];
      logic [31:0] s;
      logic [31:0] c;
      logic [15:0] ck;
      logic [15:0] iplen, udplen;
      iplen  = 16'(L - 18);
      udplen = 16'(L - 38);
      exp_q.delete();
      repeat (7) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      for (int i = 0; i < 42; i++) h[i] = 8'h00;
      for (int i = 0; i < 6; i++) h[i] = 8'hFF;
      h[6] = 8'h02; h[11] = 8'h01;
      h[12] = 8'h08; h[14] = 8'h45;
      h[16] = iplen[15:8]; h[17] = iplen[7:0];
      h[20] = 8'h40; h[22] = 8'h40; h[23] = 8'h11;
      h[26] = 8'hC0; h[27] = 8'hA8; h[29] = 8'h01;
      h[30] = 8'hC0; h[31] = 8'hA8; h[33] = 8'h02;
      h[34] = 8'h04; h[37] = 8'h07;
      h[38] = udplen[15:8]; h[39] = udplen[7:0];
      s = 0;
      for (int w = 0; w < 10; w++) s = s + {16'd0, h[14+2*w], h[15+2*w]};
      s = (s & 32'hFFFF) + (s >> 16);
      s = (s & 32'hFFFF) + (s >> 16);
      ck = ~s[15:0];
      h[24] = ck[15:8]; h[25] = ck[7:0];
      for (int i = 0; i < 42; i++) exp_q.push_back(h[i]);
      for (int i = 0; i < L - 64; i++) exp_q.push_back(8'h00);
      for (int k = 0; k < 8; k++) exp_q.push_back(seq[63-8*k -: 8]);
      for (int k = 0; k < 10; k++) exp_q.push_back(ts[79-8*k -: 8]);
      c = 32'hFFFF_FFFF;
      for (int i = 8; i < 8 + L - 4; i++) c = crc_upd(c, exp_q[i]);
      c = ~c;
      for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
   endtask

   function automatic int frame_diff();
      int n;
      n = (rx.size() < exp_q.size()) ? rx.size() : exp_q.size();
      for (int i = 0; i < n; i++) if (rx[i] !== exp_q[i]) return i;
      if (rx.size() != exp_q.size()) return n;
      return -1;
   endfunction

   function automatic logic [79:0] ts_at(input int idx);
      return (idx < rx_ts.size()) ? rx_ts[idx] : 80'd0;
   endfunction

   function automatic logic [63:0] rx_field(input int base, input int nbytes);
      logic [63:0] v;
      v = '0;
      for (int k = 0; k < nbytes; k++)
         v = {v[55:0], (base + k < rx.size()) ? rx[base+k] : 8'h00};
      return v;
   endfunction

   // Samples at negedge; each byte carries the ts value seen one cycle earlier.
   task automatic capture(output int gap, output bit ok);
      int n;
      bit started;
      logic [79:0] prev;
      rx.delete();
      rx_ts.delete();
      gap = 0;
      n = 0;
      started = 0;
      prev = {ts_sec, ts_nsec};
      while (n < 4000) begin
         @(negedge clk);
         n++;
         if (gmii_en) begin
            started = 1;
            rx.push_back(gmii_d);
            rx_ts.push_back(prev);
         end else if (started) begin
            break;
         end else begin
            gap++;
         end
         prev = {ts_sec, ts_nsec};
      end
      ok = started && !gmii_en;
   endtask

   task automatic send(input int L);
      @(negedge clk);
      start = 1'b1;
      frame_len = 11'(L);
      @(posedge clk);
      #1;
      start = 1'b0;
      frame_len = 11'($urandom);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      frame_len = 11'd0;
      repeat (3) @(negedge clk);
      checks++;
      if ({gmii_en, gmii_er, busy, frame_done} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=0000", {gmii_en, gmii_er, busy, frame_done});
      end
      checks++;
      if (gmii_d !== 8'h00) begin
         failures++;
         $display("FAIL reset_d got=%h exp=00", gmii_d);
      end
      checks++;
      if (tx_seq_num !== 64'd0) begin
         failures++;
         $display("FAIL reset_seq got=%h exp=0", tx_seq_num);
      end
      reset = 1'b0;
      exp_seq = 64'd0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, gmii_en} !== 2'b00) begin
         failures++;
         $display("FAIL idle_no_start got=%b exp=00", {busy, gmii_en});
      end
   endtask

   task automatic test_single();
      int gap;
      bit ok;
      int d;
      @(negedge clk);
      start = 1'b1;
      frame_len = 11'd64;
      @(posedge clk);
      #1;
      start = 1'b0;
      frame_len = 11'd999;
      checks++;
      if ({gmii_en, gmii_d, busy} !== {1'b1, 8'h55, 1'b1}) begin
         failures++;
         $display("FAIL accept_latency got en=%b d=%h busy=%b exp en=1 d=55 busy=1",
                  gmii_en, gmii_d, busy);
      end
      capture(gap, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL single_capture got=timeout exp=frame");
      end
      checks++;
      if (rx.size() !== 72) begin
         failures++;
         $display("FAIL single_en_cycles got=%0d exp=72", rx.size());
      end
      checks++;
      if (rx_field(44, 2) !== 64'h0007) begin
         failures++;
         $display("FAIL single_udp_port got=%h exp=0007", rx_field(44, 2));
      end
      checks++;
      if (rx_field(24, 2) !== 64'h002E) begin
         failures++;
         $display("FAIL single_ip_len got=%h exp=002e", rx_field(24, 2));
      end
      checks++;
      if (rx_field(46, 2) !== 64'h001A) begin
         failures++;
         $display("FAIL single_udp_len got=%h exp=001a", rx_field(46, 2));
      end
      build_expected(64, exp_seq, ts_at(8 + 64 - 22));
      d = frame_diff();
      checks++;
      if (d != -1) begin
         failures++;
         $display("FAIL single_frame got=mismatch@%0d exp=model", d);
      end
      checks++;
      if ({frame_done, gmii_er} !== 2'b10) begin
         failures++;
         $display("FAIL single_done got=%b exp=10", {frame_done, gmii_er});
      end
      checks++;
      if (tx_seq_num !== 64'd1) begin
         failures++;
         $display("FAIL single_seq_inc got=%h exp=1", tx_seq_num);
      end
      exp_seq++;
      repeat (12) @(negedge clk);
      checks++;
      if ({busy, frame_done} !== 2'b00) begin
         failures++;
         $display("FAIL single_ifg_end got=%b exp=00", {busy, frame_done});
      end
   endtask

   task automatic test_clamp();
      int lens[3] = '{20, 2000, 1518};
      int gap, L, d;
      bit ok;
      for (int t = 0; t < 3; t++) begin
         L = clamp_l(lens[t]);
         send(lens[t]);
         capture(gap, ok);
         checks++;
         if (rx.size() !== L + 8) begin
            failures++;
            $display("FAIL clamp_len in=%0d got=%0d exp=%0d", lens[t], rx.size(), L + 8);
         end
         checks++;
         if (rx_field(24, 2) !== 64'(L - 18)) begin
            failures++;
            $display("FAIL clamp_ip_len in=%0d got=%h exp=%h", lens[t], rx_field(24, 2), L - 18);
         end
         build_expected(L, exp_seq, ts_at(8 + L - 22));
         d = frame_diff();
         checks++;
         if (d != -1) begin
            failures++;
            $display("FAIL clamp_frame in=%0d got=mismatch@%0d exp=model", lens[t], d);
         end
         exp_seq++;
         repeat (12) @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      int gap, d;
      bit ok;
      @(negedge clk);
      start = 1'b1;
      frame_len = 11'd100;
      for (int f = 0; f < 3; f++) begin
         capture(gap, ok);
         if (f == 2) start = 1'b0;
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL b2b_capture frame=%0d got=timeout exp=frame", f);
         end
         if (f > 0) begin
            checks++;
            if (gap + 1 != 12) begin
               failures++;
               $display("FAIL b2b_ifg frame=%0d got=%0d exp=12", f, gap + 1);
            end
         end
         checks++;
         if (rx_field(8 + 100 - 22, 8) !== exp_seq) begin
            failures++;
            $display("FAIL b2b_seq frame=%0d got=%h exp=%h", f, rx_field(86, 8), exp_seq);
         end
         build_expected(100, exp_seq, ts_at(8 + 100 - 22));
         d = frame_diff();
         checks++;
         if (d != -1) begin
            failures++;
            $display("FAIL b2b_frame frame=%0d got=mismatch@%0d exp=model", f, d);
         end
         exp_seq++;
      end
      repeat (12) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL b2b_stop got=%b exp=0", busy);
      end
   endtask

   task automatic test_timestamp();
      int gap, base;
      bit ok;
      logic [79:0] got;
      send(80);
      capture(gap, ok);
      base = 8 + 80 - 22;
      got = {rx_field(base + 8, 2)[15:0], rx_field(base + 10, 8)};
      checks++;
      if (got !== ts_at(base)) begin
         failures++;
         $display("FAIL ts_latch got=%h exp=%h", got, ts_at(base));
      end
      checks++;
      if (tx_seq_num !== exp_seq + 64'd1) begin
         failures++;
         $display("FAIL ts_seq got=%h exp=%h", tx_seq_num, exp_seq + 64'd1);
      end
      exp_seq++;
      repeat (12) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int gap, d;
      bit ok;
      send(200);
      repeat (39) @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if ({gmii_en, busy} !== 2'b00) begin
         failures++;
         $display("FAIL midreset_en got=%b exp=00", {gmii_en, busy});
      end
      checks++;
      if (tx_seq_num !== 64'd0) begin
         failures++;
         $display("FAIL midreset_seq got=%h exp=0", tx_seq_num);
      end
      @(negedge clk);
      reset = 1'b0;
      exp_seq = 64'd0;
      repeat (4) @(negedge clk);
      checks++;
      if (gmii_en !== 1'b0) begin
         failures++;
         $display("FAIL midreset_no_fcs got=%b exp=0", gmii_en);
      end
      send(64);
      capture(gap, ok);
      build_expected(64, exp_seq, ts_at(8 + 64 - 22));
      d = frame_diff();
      checks++;
      if (d != -1) begin
         failures++;
         $display("FAIL midreset_next got=mismatch@%0d exp=model seq0", d);
      end
      exp_seq++;
      repeat (12) @(negedge clk);
   endtask

   task automatic test_random(input int nframes);
      int gap, L, lin, d;
      bit ok, pre_ok;
      logic [31:0] c, s;
      for (int f = 0; f < nframes; f++) begin
         lin = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2047))
                                           : int'($urandom_range(40, 180));
         L = clamp_l(lin);
         send(lin);
         capture(gap, ok);
         checks++;
         if (!ok || rx.size() != L + 8) begin
            failures++;
            $display("FAIL rnd_len frame=%0d got=%0d exp=%0d", f, rx.size(), L + 8);
         end
         pre_ok = (rx.size() >= 8);
         for (int i = 0; i < 7 && pre_ok; i++) if (rx[i] !== 8'h55) pre_ok = 0;
         if (pre_ok && rx[7] !== 8'hD5) pre_ok = 0;
         checks++;
         if (!pre_ok) begin
            failures++;
            $display("FAIL rnd_preamble frame=%0d got=bad exp=55x7_d5", f);
         end
         c = 32'hFFFF_FFFF;
         for (int i = 8; i < rx.size(); i++) c = crc_upd(c, rx[i]);
         checks++;
         if (c !== 32'hDEBB20E3) begin
            failures++;
            $display("FAIL rnd_fcs frame=%0d got=%h exp=debb20e3", f, c);
         end
         s = 0;
         for (int w = 0; w < 10; w++) s = s + 32'(rx_field(22 + 2*w, 2));
         s = (s & 32'hFFFF) + (s >> 16);
         s = (s & 32'hFFFF) + (s >> 16);
         checks++;
         if (s !== 32'hFFFF) begin
            failures++;
            $display("FAIL rnd_ipcsum frame=%0d got=%h exp=ffff", f, s);
         end
         checks++;
         if (rx_field(44, 2) !== 64'h0007) begin
            failures++;
            $display("FAIL rnd_udp_port frame=%0d got=%h exp=0007", f, rx_field(44, 2));
         end
         checks++;
         if (rx_field(8 + L - 22, 8) !== exp_seq) begin
            failures++;
            $display("FAIL rnd_seq frame=%0d got=%h exp=%h", f, rx_field(8 + L - 22, 8), exp_seq);
         end
         build_expected(L, exp_seq, ts_at(8 + L - 22));
         d = frame_diff();
         checks++;
         if (d != -1) begin
            failures++;
            $display("FAIL rnd_frame frame=%0d L=%0d got=mismatch@%0d exp=model", f, L, d);
         end
         exp_seq++;
         repeat ($urandom_range(10, 13)) @(negedge clk);
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      frame_len = 11'd0;
      exp_seq = 64'd0;
      test_reset();
      test_single();
      test_clamp();
      test_back_to_back();
      test_timestamp();
      test_reset_mid();
      test_random(80);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
